// File: rtl/circle_pkg.sv
// Shared types and widths for the audio-reactive circle renderer.
// Also used by the per-pixel circle compare logic.
package circle_pkg;

  localparam int AMP_W = 12;
  localparam int RAD_W = 8;
  localparam int RSQ_W = 16;

  localparam logic [AMP_W-1:0] MIC_MID_DEF = 12'd2048;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    CALC    = 2'd1,
    SQUARE  = 2'd2,
    PUBLISH = 2'd3
  } state_e;

  // Distance from mic midpoint; the 13-bit signed difference keeps 0 - 2048 exact (2048).
  function automatic logic [AMP_W-1:0] abs_amp(input logic [AMP_W-1:0] s,
                                                input logic [AMP_W-1:0] mid);
    logic signed [AMP_W:0] d;
    d = $signed({1'b0, s}) - $signed({1'b0, mid});
    return d[AMP_W] ? AMP_W'(-d) : AMP_W'(d);
  endfunction

endpackage

// File: rtl/seq_square8.sv
// Sequential 8x8 shift-add squarer, one multiplier bit per clock.
// start loads the operand; done is high in the cycle before the last iteration edge.
module seq_square8
  import circle_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [RAD_W-1:0] op_i,
  output logic             done_o,
  output logic [RSQ_W-1:0] prod_o
);

  logic             busy_q;
  logic [2:0]       cnt_q;
  logic [RSQ_W-1:0] mcand_q;
  logic [RAD_W-1:0] mplier_q;
  logic [RSQ_W-1:0] acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (start_i) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      mcand_q  <= {{(RSQ_W-RAD_W){1'b0}}, op_i};
      mplier_q <= op_i;
      acc_q    <= '0;
    end else if (busy_q) begin
      if (mplier_q[0]) acc_q <= acc_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 3'd1;
      if (cnt_q == 3'd7) busy_q <= 1'b0;
    end
  end

  // Early done lets the controller leave SQUARE on the same edge as the final add.
  assign done_o = busy_q && (cnt_q == 3'd7);
  assign prod_o = acc_q;

endmodule

// File: rtl/circle_radius_ctrl.sv
// Per-frame peak mic amplitude -> smoothed radius and radius^2, published 10 clocks after frame_start.
// No backpressure: frame_start arriving while busy is dropped and flagged on sticky overrun.
module circle_radius_ctrl
  import circle_pkg::*;
#(
  parameter logic [AMP_W-1:0] MIC_MID    = MIC_MID_DEF,
  parameter int               AMP_SHIFT  = 2,
  parameter int               DECAY_STEP = 4,
  parameter int               R_MAX      = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_valid,
  input  logic [AMP_W-1:0] wave_sample,
  input  logic             frame_start,
  input  logic             hold_en,
  output logic [RAD_W-1:0] radius,
  output logic [RSQ_W-1:0] radius_sq,
  output logic             radius_valid,
  output logic             overrun
);

  localparam logic [AMP_W-1:0] RMAX_A = AMP_W'(R_MAX);
  localparam logic [RAD_W-1:0] RMAX_R = RAD_W'(R_MAX);
  localparam logic [RAD_W-1:0] DSTEP  = RAD_W'(DECAY_STEP);

  state_e           state_q;
  logic [AMP_W-1:0] peak_q;
  logic [AMP_W-1:0] snap_q;
  logic [RAD_W-1:0] new_r_q;
  logic [RAD_W-1:0] radius_q;
  logic [RSQ_W-1:0] radius_sq_q;
  logic             radius_valid_q;
  logic             overrun_q;

  logic [AMP_W-1:0] amp;
  logic [AMP_W-1:0] peak_d;
  logic             accept;
  logic [AMP_W-1:0] shifted;
  logic [RAD_W-1:0] target;
  logic [RAD_W-1:0] gap;
  logic [RAD_W-1:0] new_r_d;
  logic             sq_start;
  logic             sq_done;
  logic [RSQ_W-1:0] sq_prod;

  assign amp    = abs_amp(wave_sample, MIC_MID);
  // Includes a same-cycle sample, so it lands in the frame being closed.
  assign peak_d = (sample_valid && (amp > peak_q)) ? amp : peak_q;
  assign accept = frame_start && (state_q == ACCUM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_q <= '0;
    end else if (accept) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  always_comb begin
    shifted = snap_q >> AMP_SHIFT;
    target  = (shifted > RMAX_A) ? RMAX_R : shifted[RAD_W-1:0];
    gap     = '0;
    new_r_d = target;
    if (target < radius_q) begin
      gap     = radius_q - target;
      new_r_d = radius_q - ((gap > DSTEP) ? DSTEP : gap);
    end
  end

  assign sq_start = (state_q == CALC);

  seq_square8 u_square (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (sq_start),
    .op_i    (new_r_d),
    .done_o  (sq_done),
    .prod_o  (sq_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ACCUM;
      snap_q         <= '0;
      new_r_q        <= '0;
      radius_q       <= '0;
      radius_sq_q    <= '0;
      radius_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      radius_valid_q <= 1'b0;
      if (frame_start && (state_q != ACCUM)) overrun_q <= 1'b1;
      case (state_q)
        ACCUM: begin
          if (frame_start) begin
            snap_q  <= peak_d;
            state_q <= CALC;
          end
        end
        CALC: begin
          new_r_q <= new_r_d;
          state_q <= SQUARE;
        end
        SQUARE: begin
          if (sq_done) state_q <= PUBLISH;
        end
        PUBLISH: begin
          if (!hold_en) begin
            radius_q       <= new_r_q;
            radius_sq_q    <= sq_prod;
            radius_valid_q <= 1'b1;
          end
          state_q <= ACCUM;
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign radius       = radius_q;
  assign radius_sq    = radius_sq_q;
  assign radius_valid = radius_valid_q;
  assign overrun      = overrun_q;

endmodule
